alu_unit: RTL and testbench

ALU_UNIT -- requirements
Module: alu_unit

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_mul.sv | 40 ++++
 rtl/alu_unit.sv | 92 +++++++++
 tb/tb_alu_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared op encodings and FSM state constants for alu_unit
package alu_pkg;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;
  localparam logic ST_IDLE    = 1'b0;
  localparam logic ST_MUL_RUN = 1'b1;
endpackage

// File: rtl/alu_mul.sv
// alu_mul: shift-add multiplier datapath, one step per cycle, LSB of multiplier first
// Ports: CLK, RESET (sync, active-high); load captures a/b and clears acc/counter;
//        run performs one step; last flags the final step; prod is the product after this step.
module alu_mul #(
  parameter int DATA_W = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  load,
  input  logic                  run,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  last,
  output logic [2*DATA_W-1:0]   prod
);
  localparam int CW = $clog2(DATA_W);
  logic [2*DATA_W-1:0] acc, mcand;
  logic [DATA_W-1:0] mplier;
  logic [CW-1:0] cnt;
  assign last = cnt == CW'(DATA_W - 1);
  // Product including the step taking place on this edge, so the top can latch it on the final edge.
  assign prod = acc + (mplier[0] ? mcand : '0);
  always_ff @(posedge CLK)
    if (RESET) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{DATA_W{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
    end else if (run) begin
      acc    <= prod;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
endmodule

// File: rtl/alu_unit.sv
// alu_unit: 8-op ALU with single-cycle logic/arith ops and a multi-cycle shift-add multiply
// Ports: CLK, RESET (sync, active-high); a_in/b_in operands; op select; start request;
//        OE gates the result register onto alu_out; busy/done/carry/zero/neg status are registered.
module alu_unit import alu_pkg::*; #(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [2:0]        op,
  input  logic              start,
  input  logic              OE,
  output logic [DATA_W-1:0] alu_out,
  output logic              busy,
  output logic              done,
  output logic              carry_flag,
  output logic              zero_flag,
  output logic              neg_flag
);
  logic state, c_n, w_c, last, go_alu, go_mul, mul_fin;
  logic [DATA_W:0] ext;
  logic [DATA_W-1:0] res_n, w_res, result;
  logic [2*DATA_W-1:0] prod;
  assign go_alu  = state == ST_IDLE && start && op != OP_MUL;
  assign go_mul  = state == ST_IDLE && start && op == OP_MUL;
  assign mul_fin = state == ST_MUL_RUN && last;
  alu_mul #(.DATA_W(DATA_W)) u_mul (
    .CLK   (CLK),
    .RESET (RESET),
    .load  (go_mul),
    .run   (state == ST_MUL_RUN),
    .a     (a_in),
    .b     (b_in),
    .last  (last),
    .prod  (prod)
  );
  always_comb begin
    ext   = '0;
    res_n = '0;
    c_n   = 1'b0;
    case (op)
      OP_ADD: begin
        ext   = {1'b0, a_in} + {1'b0, b_in};
        res_n = ext[DATA_W-1:0];
        c_n   = ext[DATA_W];
      end
      OP_SUB: begin
        ext   = {1'b0, a_in} - {1'b0, b_in};
        res_n = ext[DATA_W-1:0];
        c_n   = ~ext[DATA_W];
      end
      OP_AND: res_n = a_in & b_in;
      OP_OR:  res_n = a_in | b_in;
      OP_XOR: res_n = a_in ^ b_in;
      OP_NOT: res_n = ~a_in;
      OP_SHL: begin
        res_n = {a_in[DATA_W-2:0], 1'b0};
        c_n   = a_in[DATA_W-1];
      end
      default: ;
    endcase
  end
  assign w_res = mul_fin ? prod[DATA_W-1:0] : res_n;
  assign w_c   = mul_fin ? |prod[2*DATA_W-1:DATA_W] : c_n;
  always_ff @(posedge CLK)
    if (RESET) begin
      state      <= ST_IDLE;
      result     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b1;
      neg_flag   <= 1'b0;
    end else begin
      done <= go_alu || mul_fin;
      if (go_alu || mul_fin) begin
        result     <= w_res;
        carry_flag <= w_c;
        zero_flag  <= w_res == '0;
        neg_flag   <= w_res[DATA_W-1];
      end
      if (go_mul) begin
        state <= ST_MUL_RUN;
        busy  <= 1'b1;
      end else if (mul_fin) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end
    end
  assign alu_out = OE ? result : '0;
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: scoreboard-driven self-checking bench for alu_unit
module tb_alu_unit;
  import alu_pkg::*;
  logic CLK = 1'b0, RESET = 1'b1, start = 1'b0, OE = 1'b1;
  logic [7:0] a_in = '0, b_in = '0, alu_out;
  logic [2:0] op = '0;
  logic busy, done, carry_flag, zero_flag, neg_flag;
  typedef struct packed {logic [7:0] r; logic c; logic z; logic n;} exp_t;
  exp_t sb[$];
  exp_t e, le = '{r: 8'h00, c: 1'b0, z: 1'b1, n: 1'b0};
  logic [10:0] got;
  int vectors = 0, miscompares = 0;
  alu_unit #(.DATA_W(8)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .a_in       (a_in),
    .b_in       (b_in),
    .op         (op),
    .start      (start),
    .OE         (OE),
    .alu_out    (alu_out),
    .busy       (busy),
    .done       (done),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .neg_flag   (neg_flag)
  );
  always #5 CLK = ~CLK;
  function automatic exp_t model(logic [2:0] o, logic [7:0] a, logic [7:0] b);
    int x, y, v;
    logic c;
    x = int'(a);
    y = int'(b);
    c = 1'b0;
    case (o)
      OP_ADD: begin v = x + y; c = v > 255; end
      OP_SUB: begin v = x - y; c = x >= y; end
      OP_AND: v = x & y;
      OP_OR:  v = x | y;
      OP_XOR: v = x ^ y;
      OP_NOT: v = ~x;
      OP_SHL: begin v = x * 2; c = x >= 128; end
      default: begin v = x * y; c = v > 255; end
    endcase
    v = v & 255;
    return '{r: 8'(v), c: c, z: v == 0, n: v >= 128};
  endfunction
  task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    @(negedge CLK);
    op = o; a_in = a; b_in = b; start = 1'b1;
    sb.push_back(model(o, a, b));
    @(negedge CLK);
    start = 1'b0;
  endtask
  task automatic wait_done(output int l, output int bc);
    l = 1;
    bc = int'(busy);
    while (!done && l < 40) begin
      @(negedge CLK);
      l++;
      bc += int'(busy);
    end
  endtask
  task automatic test_reset;
    RESET = 1'b1; start = 1'b1; op = OP_ADD; a_in = 8'hFF; b_in = 8'h01;
    repeat (3) @(negedge CLK);
    vectors++;
    if ({alu_out, carry_flag, zero_flag, neg_flag, busy, done} !== 13'b00000000_010_00) begin
      miscompares++;
      $display("FAIL reset: got out=%h c=%b z=%b n=%b busy=%b done=%b, need out=00 c=0 z=1 n=0 busy=0 done=0",
               alu_out, carry_flag, zero_flag, neg_flag, busy, done);
    end
    RESET = 1'b0; start = 1'b0;
  endtask
  task automatic test_alu_ops;
    logic [2:0] ops [10] = '{OP_ADD, OP_SUB, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHL, OP_ADD};
    logic [7:0] as [10] = '{8'hF0, 8'h05, 8'h03, 8'hF0, 8'h0F, 8'hAA, 8'h5A, 8'h81, 8'h40, 8'hFF};
    logic [7:0] bs [10] = '{8'h20, 8'h05, 8'h05, 8'h3C, 8'h30, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h01};
    int l, bc;
    for (int i = 0; i < 10; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_done(l, bc);
      vectors++;
      if (l != 1) begin
        miscompares++;
        $display("FAIL alu_latency[%0d]: got %0d cycles, need 1", i, l);
      end
      e = sb.pop_front();
      le = e;
      got = {alu_out, carry_flag, zero_flag, neg_flag};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL alu_result[%0d] op=%0d a=%h b=%h: got r=%h czn=%b, need r=%h czn=%b",
                 i, ops[i], as[i], bs[i], got[10:3], got[2:0], e.r, {e.c, e.z, e.n});
      end
      @(negedge CLK);
      got = {alu_out, carry_flag, zero_flag, neg_flag};
      vectors++;
      if (done !== 1'b0 || got !== e) begin
        miscompares++;
        $display("FAIL alu_hold[%0d]: got done=%b r=%h czn=%b, need done=0 r=%h czn=%b",
                 i, done, got[10:3], got[2:0], e.r, {e.c, e.z, e.n});
      end
    end
  endtask
  task automatic test_oe;
    OE = 1'b0;
    #1;
    vectors++;
    if ({alu_out, carry_flag, zero_flag, neg_flag} !== {8'h00, le.c, le.z, le.n}) begin
      miscompares++;
      $display("FAIL oe_low: got out=%h czn=%b, need out=00 czn=%b", alu_out, {carry_flag, zero_flag, neg_flag}, {le.c, le.z, le.n});
    end
    OE = 1'b1;
    #1;
    vectors++;
    if ({alu_out, carry_flag, zero_flag, neg_flag} !== le) begin
      miscompares++;
      $display("FAIL oe_high: got out=%h czn=%b, need out=%h czn=%b", alu_out, {carry_flag, zero_flag, neg_flag}, le.r, {le.c, le.z, le.n});
    end
  endtask
  task automatic test_mul;
    logic [7:0] as [2] = '{8'h0C, 8'h20};
    logic [7:0] bs [2] = '{8'h0D, 8'h10};
    int l, bc;
    for (int i = 0; i < 2; i++) begin
      issue(OP_MUL, as[i], bs[i]);
      op = OP_ADD; a_in = 8'hFF; b_in = 8'hFF;
      l = 1;
      bc = int'(busy);
      while (!done && l < 40) begin
        if (l == 4) begin
          vectors++;
          if (alu_out !== le.r) begin
            miscompares++;
            $display("FAIL mul_prev_result[%0d]: got %h, need %h", i, alu_out, le.r);
          end
        end
        @(negedge CLK);
        l++;
        bc += int'(busy);
      end
      vectors++;
      if (l != 9 || bc != 8) begin
        miscompares++;
        $display("FAIL mul_timing[%0d]: got done at %0d busy %0d cycles, need 9 and 8", i, l, bc);
      end
      e = sb.pop_front();
      le = e;
      got = {alu_out, carry_flag, zero_flag, neg_flag};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL mul_result[%0d] %h*%h: got r=%h czn=%b, need r=%h czn=%b",
                 i, as[i], bs[i], got[10:3], got[2:0], e.r, {e.c, e.z, e.n});
      end
      @(negedge CLK);
      vectors++;
      if (done !== 1'b0) begin
        miscompares++;
        $display("FAIL mul_done_pulse[%0d]: got done=%b, need 0", i, done);
      end
    end
  endtask
  task automatic test_busy_start;
    int dn = 0, first = 0;
    issue(OP_MUL, 8'h0C, 8'h0D);
    for (int l = 1; l <= 14; l++) begin
      if (done) begin
        dn++;
        if (first == 0) first = l;
      end
      start = (l == 3 || l == 8);
      op = OP_ADD; a_in = 8'h01; b_in = 8'h01;
      @(negedge CLK);
    end
    start = 1'b0;
    vectors++;
    if (dn != 1 || first != 9) begin
      miscompares++;
      $display("FAIL busy_start_done: got %0d pulses first at %0d, need 1 at 9", dn, first);
    end
    e = sb.pop_front();
    le = e;
    got = {alu_out, carry_flag, zero_flag, neg_flag};
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL busy_start_result: got r=%h czn=%b, need r=%h czn=%b", got[10:3], got[2:0], e.r, {e.c, e.z, e.n});
    end
  endtask
  task automatic test_mul_reset;
    int dn = 0, l, bc;
    issue(OP_MUL, 8'h0C, 8'h0D);
    e = sb.pop_back();
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    le = '{r: 8'h00, c: 1'b0, z: 1'b1, n: 1'b0};
    vectors++;
    if ({alu_out, carry_flag, zero_flag, neg_flag, busy, done} !== 13'b00000000_010_00) begin
      miscompares++;
      $display("FAIL mul_reset: got out=%h czn=%b busy=%b done=%b, need out=00 czn=010 busy=0 done=0",
               alu_out, {carry_flag, zero_flag, neg_flag}, busy, done);
    end
    repeat (12) begin
      if (done) dn++;
      @(negedge CLK);
    end
    vectors++;
    if (dn != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mul_reset_quiet: got %0d done pulses busy=%b, need 0 and busy=0", dn, busy);
    end
    issue(OP_ADD, 8'h01, 8'h01);
    wait_done(l, bc);
    e = sb.pop_front();
    le = e;
    got = {alu_out, carry_flag, zero_flag, neg_flag};
    vectors++;
    if (got !== e || l != 1) begin
      miscompares++;
      $display("FAIL post_reset_add: got r=%h czn=%b lat=%0d, need r=%h czn=%b lat=1", got[10:3], got[2:0], l, e.r, {e.c, e.z, e.n});
    end
  endtask
  task automatic test_back_to_back;
    @(negedge CLK);
    op = OP_ADD; a_in = 8'h7F; b_in = 8'h01; start = 1'b1;
    sb.push_back(model(OP_ADD, 8'h7F, 8'h01));
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      if (i == 0) begin
        op = OP_XOR; a_in = 8'h55; b_in = 8'hFF;
        sb.push_back(model(OP_XOR, 8'h55, 8'hFF));
      end else start = 1'b0;
      e = sb.pop_front();
      le = e;
      got = {alu_out, carry_flag, zero_flag, neg_flag};
      vectors++;
      if (done !== 1'b1 || got !== e) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got done=%b r=%h czn=%b, need done=1 r=%h czn=%b", i, done, got[10:3], got[2:0], e.r, {e.c, e.z, e.n});
      end
    end
    @(negedge CLK);
    vectors++;
    if (done !== 1'b0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL back_to_back_end: got done=%b queue=%0d, need done=0 queue=0", done, sb.size());
    end
  endtask
  initial begin
    test_reset;
    test_alu_ops;
    test_oe;
    test_mul;
    test_oe;
    test_busy_start;
    test_mul_reset;
    test_back_to_back;
    test_oe;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
